gray_seq_gen: RTL and testbench
===============================

Name: gray_seq_gen

Overview:
- Sequential Gray-code source that emits a burst of consecutive standard Gray-code values over a valid/ready stream.
- Sits directly upstream of the Gray-to-binary converter: its gray output drives the converter's gray input, so the converter's bin output reproduces the running index.
- The burst is started by a one-cycle start pulse and is back-pressure aware.

Parameters:
- DATA_WIDTH, 16, width of the Gray code word, the internal index and the length field; legal values are >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse that begins a burst; sampled only in IDLE
- count_len  input  DATA_WIDTH  number of codes in the burst, sampled with start; 0 means 2^DATA_WIDTH codes
- out_ready  input  1  downstream accepts the current code
- out_valid  output  1  gray holds a valid code
- gray  output  DATA_WIDTH  current Gray code, registered; equals idx ^ (idx >> 1)
- last  output  1  high together with out_valid on the final code of the burst
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset values, applied asynchronously while reset is high: state=IDLE, out_valid=0, gray=0, last=0, busy=0, done=0, internal idx=0, internal remaining=0.
- Handshake: a transfer occurs on a rising edge where out_valid && out_ready are both high.
  - While out_valid=1 and out_ready=0, gray and last hold stable.
  - out_valid never drops without a transfer, except on reset.
- IDLE:
  - out_valid=0, busy=0.
  - start=1 at an edge: idx<=0, gray<=0, remaining<=count_len (0 is encoded as 2^DATA_WIDTH, held in a DATA_WIDTH+1-bit counter), last<=(effective length==1), go to RUN.
  - out_valid rises the cycle after start (latency 1).
- RUN:
  - out_valid=1, busy=1. start is ignored.
  - On a transfer with remaining>1: idx<=idx+1 modulo 2^DATA_WIDTH; gray<=next_idx ^ (next_idx>>1); remaining<=remaining-1; last<=(remaining==2).
  - On a transfer with remaining==1: go to DONE, out_valid<=0, last<=0.
  - Throughput: one code per cycle while out_ready is held high.
- DONE:
  - done=1 for exactly one cycle, out_valid=0, busy=0; go to IDLE.
  - start asserted during DONE is ignored.
- Wrap-around: idx wraps from 2^DATA_WIDTH-1 to 0. A full-length burst (count_len=0) ends on the code for idx 2^DATA_WIDTH-1, i.e. 1 followed by zeros; no wrap is emitted within that burst.
- Consecutive emitted codes differ in exactly one bit.
- DATA_WIDTH=1: sequence is 0,1; count_len=0 gives 2 codes.
- Reset asserted mid-burst: immediately returns all outputs to their reset values and discards the burst; no done pulse.

Optional Feature:
- Macro: GRAY_SEQ_GEN_START_IDX_EN.
- When defined:
  - Adds input start_idx [DATA_WIDTH-1:0], sampled with start.
  - The burst begins at idx=start_idx, so the first gray is start_idx ^ (start_idx>>1).
  - Wrap-around from 2^DATA_WIDTH-1 to 0 can occur within the burst.
  - Length and last/done rules are unchanged.
- When undefined: the port does not exist and every burst begins at idx=0.

Test Plan:
- DATA_WIDTH=4, start with count_len=5, out_ready=1 -> gray 0x0,0x1,0x3,0x2,0x6 on consecutive cycles starting 1 cycle after start; last with 0x6; done 1 cycle after the 0x6 transfer.
- count_len=4, out_ready toggling 1,0,0,1,... -> each code held while out_ready=0; exactly 4 transfers 0x0,0x1,0x3,0x2; no duplicate or skipped code.
- DATA_WIDTH=4, count_len=0 -> 16 codes ending 0x8, last on 0x8; each pair differs by one bit; the downstream converter's bin equals 0..15.
- count_len=1 -> a single 0x0 with last=1 on the same beat; done next cycle; start pulsed during RUN/DONE has no effect.
- Reset asserted on the third beat of a count_len=6 burst -> out_valid, busy, last and gray go to 0 without waiting for a clock edge; no done; a new start then begins again at 0x0.
- With GRAY_SEQ_GEN_START_IDX_EN, DATA_WIDTH=4, start_idx=14, count_len=4 -> gray 0x9,0x8,0x0,0x1 (wrap 15->0).

Source files
------------

// File: rtl/gray_seq_gen.sv
// Burst source of consecutive Gray codes on a valid/ready stream.
// Optional GRAY_SEQ_GEN_START_IDX_EN adds a start_idx input for the first index.
module gray_seq_gen #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] count_len,
`ifdef GRAY_SEQ_GEN_START_IDX_EN
   input  logic [DATA_WIDTH-1:0] start_idx,
`endif
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] gray,
   output logic                  last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] idx, idx_inc, first_idx;
   logic [DATA_WIDTH:0]   remaining, len_eff;
   logic                  xfer, final_beat;

`ifdef GRAY_SEQ_GEN_START_IDX_EN
   assign first_idx = start_idx;
`else
   assign first_idx = '0;
`endif

   // A zero length means the full 2^DATA_WIDTH codes, hence the extra counter bit.
   assign len_eff    = (count_len == '0) ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, count_len};
   assign idx_inc    = idx + DATA_WIDTH'(1);
   assign xfer       = (state == RUN) && out_ready;
   assign final_beat = (remaining == (DATA_WIDTH+1)'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (xfer && final_beat) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         gray      <= '0;
         remaining <= '0;
         last      <= 1'b0;
      end else if (state == IDLE && start) begin
         idx       <= first_idx;
         gray      <= first_idx ^ (first_idx >> 1);
         remaining <= len_eff;
         last      <= (len_eff == (DATA_WIDTH+1)'(1));
      end else if (xfer) begin
         if (final_beat) begin
            last <= 1'b0;
         end else begin
            idx       <= idx_inc;
            gray      <= idx_inc ^ (idx_inc >> 1);
            remaining <= remaining - (DATA_WIDTH+1)'(1);
            last      <= (remaining == (DATA_WIDTH+1)'(2));
         end
      end
   end

endmodule

// File: tb/tb_gray_seq_gen.sv
// Scoreboard bench for gray_seq_gen at DATA_WIDTH=4.
module tb_gray_seq_gen;
   localparam int DW = 4;

   logic          clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] count_len = '0;
   logic [DW-1:0] start_idx = '0;
   logic          out_valid, last, busy, done;
   logic [DW-1:0] gray;

   int vectors = 0, errors = 0;
   int cyc = 0, last_xfer_cyc = -10, done_cnt = 0, xfer_cnt = 0;

   typedef struct packed {logic [DW-1:0] g; logic l; logic [DW-1:0] i;} exp_t;
   exp_t sb[$];

   logic          have_prev = 1'b0, stall_pend = 1'b0, stall_l;
   logic [DW-1:0] prev_g, stall_g;

   gray_seq_gen #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .count_len(count_len),
`ifdef GRAY_SEQ_GEN_START_IDX_EN
      .start_idx(start_idx),
`endif
      .out_ready(out_ready), .out_valid(out_valid), .gray(gray),
      .last(last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Models the downstream Gray-to-binary converter.
   function automatic logic [DW-1:0] gray2bin(input logic [DW-1:0] g);
      logic [DW-1:0] b;
      b[DW-1] = g[DW-1];
      for (int k = DW-2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
      return b;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            chk("valid_hold", out_valid, 1);
            if (out_valid) begin
               chk("hold_gray", gray, stall_g);
               chk("hold_last", last, stall_l);
            end
         end
         stall_pend = out_valid && !out_ready;
         stall_g    = gray;
         stall_l    = last;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("extra_xfer", sb.size(), 1);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("gray", gray, e.g);
               chk("last", last, e.l);
               chk("bin", gray2bin(gray), e.i);
               if (have_prev) chk("onebit", $countones(gray ^ prev_g), 1);
               have_prev = 1'b1;
               prev_g    = gray;
            end
            last_xfer_cyc = cyc;
            xfer_cnt++;
         end
         if (done) begin
            done_cnt++;
            chk("done_lat", cyc, last_xfer_cyc + 1);
         end
      end
   end

   // mode 0: ready always; 1: ready pattern 1,0,0; 2: stall 2 cycles with start held, restart in DONE
   task automatic run_burst(input int len, input int sidx, input int mode);
      int n, x0, d0;
      bit got;
      n  = (len == 0) ? (1 << DW) : len;
      for (int k = 0; k < n; k++) begin
         exp_t e;
         e.i = DW'(sidx + k);
         e.g = e.i ^ (e.i >> 1);
         e.l = (k == n-1);
         sb.push_back(e);
      end
      have_prev = 1'b0;
      x0 = xfer_cnt;
      d0 = done_cnt;
      got = 0;
      @(posedge clk); #1;
      start = 1'b1; count_len = DW'(len); start_idx = DW'(sidx);
      @(posedge clk); #1;
      chk("lat_valid", out_valid, 1);
      chk("busy_run", busy, 1);
      start = (mode == 2);
      count_len = DW'(3);
      for (int k = 0; k < 300; k++) begin
         case (mode)
            1:       out_ready = (k % 3 == 0);
            2:       begin out_ready = (k >= 2); if (k >= 2) start = 1'b0; end
            default: out_ready = 1'b1;
         endcase
         @(negedge clk);
         if (done) begin got = 1; break; end
         @(posedge clk); #1;
      end
      chk("timeout", got, 1);
      if (mode == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("done_1cyc", done, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("xfers", xfer_cnt - x0, n);
      chk("done_cnt", done_cnt - d0, 1);
      chk("sb_empty", sb.size(), 0);
      sb.delete();
      out_ready = 1'b0;
   endtask

   initial begin
      int d0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_last", last, 0);
      chk("rst_gray", gray, 0);
      @(posedge clk); #1 reset = 1'b0;

      run_burst(5, 0, 0);
      run_burst(4, 0, 1);
      run_burst(0, 0, 0);
      run_burst(1, 0, 2);

      // Mid-burst reset on the third beat
      for (int k = 0; k < 6; k++) begin
         exp_t e;
         e.i = DW'(k); e.g = e.i ^ (e.i >> 1); e.l = (k == 5);
         sb.push_back(e);
      end
      have_prev = 1'b0;
      d0 = done_cnt;
      @(posedge clk); #1 start = 1'b1; count_len = DW'(6); out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("beat3_gray", gray, 4'h3);
      reset = 1'b1;
      #1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_last", last, 0);
      chk("mrst_gray", gray, 0);
      #1 reset = 1'b0;
      sb.delete();
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("mrst_nodone", done_cnt - d0, 0);
      run_burst(3, 0, 0);

`ifdef GRAY_SEQ_GEN_START_IDX_EN
      run_burst(4, 14, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
